// File: rtl/ika9958_vram_arb.sv
// ika9958_vram_arb: VRAM slot arbiter.
// Each slot strobe from the timing generator opens one VRAM access. Display slots (with the
// display enabled) belong to the display fetcher. All other slots are shared between the CPU
// port and the command engine, and the priority between them alternates. One access runs at a
// time through IDLE -> ISSUE -> WAIT -> DONE, and the winner gets read data plus an ack/valid.
//
// Ports:
//   i_XTAL1, i_RST                       clock, synchronous active-high reset
//   i_SLOT_STB, i_SLOT_DISP, i_DISP_EN   slot timing and display enable
//   i_DISP_ADDR, o_DISP_DATA, o_DISP_VLD display fetch channel
//   i_CPU_* / o_CPU_*                    CPU request/completion channel
//   i_CMD_* / o_CMD_*                    command engine request/completion channel
//   o_VA, o_VD_OUT, o_VRD, o_VWR, i_VD_IN VRAM pin interface
//   o_OVERRUN                            sticky flag: a slot arrived while busy
module ika9958_vram_arb #(
  parameter int unsigned AW  = 17,
  parameter int unsigned DW  = 8,
  parameter int unsigned LAT = 2
) (
  input  logic          i_XTAL1,
  input  logic          i_RST,
  input  logic          i_SLOT_STB,
  input  logic          i_SLOT_DISP,
  input  logic          i_DISP_EN,
  input  logic [AW-1:0] i_DISP_ADDR,
  output logic [DW-1:0] o_DISP_DATA,
  output logic          o_DISP_VLD,
  input  logic          i_CPU_REQ,
  input  logic          i_CPU_WR,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_WDATA,
  output logic          o_CPU_ACK,
  output logic [DW-1:0] o_CPU_RDATA,
  input  logic          i_CMD_REQ,
  input  logic          i_CMD_WR,
  input  logic [AW-1:0] i_CMD_ADDR,
  input  logic [DW-1:0] i_CMD_WDATA,
  output logic          o_CMD_ACK,
  output logic [DW-1:0] o_CMD_RDATA,
  output logic [AW-1:0] o_VA,
  output logic [DW-1:0] o_VD_OUT,
  output logic          o_VRD,
  output logic          o_VWR,
  input  logic [DW-1:0] i_VD_IN,
  output logic          o_OVERRUN
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [1:0] {OwnNone, OwnDisp, OwnCpu, OwnCmd} owner_e;

  // WAIT-cycle counter start value: WAIT lasts LAT-1 clocks, counted down to zero.
  localparam logic [2:0] WaitInit = (LAT > 1) ? 3'(LAT - 2) : 3'd0;

  state_e     state;
  owner_e     owner;
  owner_e     win;
  logic       prio_cmd;   // 1: command engine wins a contended free slot
  logic [2:0] wait_cnt;
  logic       last_phase; // final strobe cycle; next clock is DONE

  // Owner decision for a strobe seen in IDLE.
  always_comb begin
    win = OwnNone;
    if (i_SLOT_DISP && i_DISP_EN) begin
      win = OwnDisp;
    end else if (i_CPU_REQ && i_CMD_REQ) begin
      win = prio_cmd ? OwnCmd : OwnCpu;
    end else if (i_CPU_REQ) begin
      win = OwnCpu;
    end else if (i_CMD_REQ) begin
      win = OwnCmd;
    end
  end

  always_comb begin
    last_phase = ((state == StIssue) && (LAT == 1)) || ((state == StWait) && (wait_cnt == 3'd0));
  end

  always_ff @(posedge i_XTAL1) begin
    if (i_RST) begin
      state       <= StIdle;
      owner       <= OwnNone;
      prio_cmd    <= 1'b0;
      wait_cnt    <= 3'd0;
      o_VA        <= '0;
      o_VD_OUT    <= '0;
      o_VRD       <= 1'b0;
      o_VWR       <= 1'b0;
      o_DISP_DATA <= '0;
      o_DISP_VLD  <= 1'b0;
      o_CPU_ACK   <= 1'b0;
      o_CPU_RDATA <= '0;
      o_CMD_ACK   <= 1'b0;
      o_CMD_RDATA <= '0;
      o_OVERRUN   <= 1'b0;
    end else begin
      o_DISP_VLD <= 1'b0;
      o_CPU_ACK  <= 1'b0;
      o_CMD_ACK  <= 1'b0;

      if (i_SLOT_STB && (state != StIdle)) begin
        o_OVERRUN <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (i_SLOT_STB && (win != OwnNone)) begin
            owner <= win;
            state <= StIssue;
            case (win)
              OwnDisp: begin
                o_VA  <= i_DISP_ADDR;
                o_VRD <= 1'b1;
              end
              OwnCpu: begin
                o_VA     <= i_CPU_ADDR;
                o_VRD    <= ~i_CPU_WR;
                o_VWR    <= i_CPU_WR;
                prio_cmd <= 1'b1;
                if (i_CPU_WR) o_VD_OUT <= i_CPU_WDATA;
              end
              OwnCmd: begin
                o_VA     <= i_CMD_ADDR;
                o_VRD    <= ~i_CMD_WR;
                o_VWR    <= i_CMD_WR;
                prio_cmd <= 1'b0;
                if (i_CMD_WR) o_VD_OUT <= i_CMD_WDATA;
              end
              default: ;
            endcase
          end
        end
        StIssue: begin
          state    <= last_phase ? StDone : StWait;
          wait_cnt <= WaitInit;
        end
        StWait: begin
          if (last_phase) begin
            state <= StDone;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        StDone: begin
          state <= StIdle;
          owner <= OwnNone;
        end
      endcase

      // Entering DONE: drop strobes, capture read data, and signal completion to the owner.
      if (last_phase) begin
        o_VRD <= 1'b0;
        o_VWR <= 1'b0;
        case (owner)
          OwnDisp: begin
            o_DISP_DATA <= i_VD_IN;
            o_DISP_VLD  <= 1'b1;
          end
          OwnCpu: begin
            if (o_VRD) o_CPU_RDATA <= i_VD_IN;
            o_CPU_ACK <= 1'b1;
          end
          OwnCmd: begin
            if (o_VRD) o_CMD_RDATA <= i_VD_IN;
            o_CMD_ACK <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ika9958_vram_arb.sv
// Directed bench for ika9958_vram_arb with LAT=2.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_ika9958_vram_arb;

  localparam int unsigned AW  = 17;
  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          slot_stb, slot_disp, disp_en;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_vld;
  logic          cpu_req, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          cmd_req, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, cmd_rdata;
  logic          cmd_ack;
  logic [AW-1:0] va;
  logic [DW-1:0] vd_out, vd_in;
  logic          vrd, vwr, overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ika9958_vram_arb #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .i_XTAL1    (clk),
    .i_RST      (rst),
    .i_SLOT_STB (slot_stb),
    .i_SLOT_DISP(slot_disp),
    .i_DISP_EN  (disp_en),
    .i_DISP_ADDR(disp_addr),
    .o_DISP_DATA(disp_data),
    .o_DISP_VLD (disp_vld),
    .i_CPU_REQ  (cpu_req),
    .i_CPU_WR   (cpu_wr),
    .i_CPU_ADDR (cpu_addr),
    .i_CPU_WDATA(cpu_wdata),
    .o_CPU_ACK  (cpu_ack),
    .o_CPU_RDATA(cpu_rdata),
    .i_CMD_REQ  (cmd_req),
    .i_CMD_WR   (cmd_wr),
    .i_CMD_ADDR (cmd_addr),
    .i_CMD_WDATA(cmd_wdata),
    .o_CMD_ACK  (cmd_ack),
    .o_CMD_RDATA(cmd_rdata),
    .o_VA       (va),
    .o_VD_OUT   (vd_out),
    .o_VRD      (vrd),
    .o_VWR      (vwr),
    .i_VD_IN    (vd_in),
    .o_OVERRUN  (overrun)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; slot_stb = 1'b0; slot_disp = 1'b0; disp_en = 1'b1; disp_addr = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; vd_in = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_vrd", 32'(vrd), 32'd0);
    chk("rst_vwr", 32'(vwr), 32'd0);
    chk("rst_va", 32'(va), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_disp_vld", 32'(disp_vld), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    tick(1);

    // Display read; CPU request held must not be served in this slot.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00200;
    slot_disp = 1'b1; disp_en = 1'b1; disp_addr = 17'h1A2B0; vd_in = 8'h5C;
    slot_stb = 1'b1;
    tick(1);
    slot_stb = 1'b0; cpu_req = 1'b0;
    chk("disp_issue_vrd", 32'(vrd), 32'd1);
    chk("disp_issue_va", 32'(va), 32'h1A2B0);
    chk("disp_issue_vwr", 32'(vwr), 32'd0);
    tick(1);
    chk("disp_wait_vrd", 32'(vrd), 32'd1);
    chk("disp_wait_va", 32'(va), 32'h1A2B0);
    tick(1);
    chk("disp_done_vld", 32'(disp_vld), 32'd1);
    chk("disp_done_data", 32'(disp_data), 32'h5C);
    chk("disp_done_vrd", 32'(vrd), 32'd0);
    chk("disp_cpu_noack", 32'(cpu_ack), 32'd0);
    tick(1);
    chk("disp_vld_pulse", 32'(disp_vld), 32'd0);
    chk("disp_cpu_noack2", 32'(cpu_ack), 32'd0);
    tick(1);

    // CPU write in a free slot.
    slot_disp = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h00100; cpu_wdata = 8'hA5;
    slot_stb = 1'b1;
    tick(1);
    slot_stb = 1'b0;
    chk("wr_issue_vwr", 32'(vwr), 32'd1);
    chk("wr_issue_vrd", 32'(vrd), 32'd0);
    chk("wr_issue_vd", 32'(vd_out), 32'hA5);
    chk("wr_issue_va", 32'(va), 32'h00100);
    tick(1);
    chk("wr_wait_vwr", 32'(vwr), 32'd1);
    tick(1);
    chk("wr_done_ack", 32'(cpu_ack), 32'd1);
    chk("wr_done_vwr", 32'(vwr), 32'd0);
    chk("wr_rdata_kept", 32'(cpu_rdata), 32'h00);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    tick(1);
    chk("wr_ack_pulse", 32'(cpu_ack), 32'd0);
    tick(1);

    // Blanked display slot is free: command engine read wins.
    disp_en = 1'b0; slot_disp = 1'b1;
    cmd_req = 1'b1; cmd_wr = 1'b0; cmd_addr = 17'h1FFFF; vd_in = 8'h3E;
    slot_stb = 1'b1;
    tick(1);
    slot_stb = 1'b0;
    chk("blank_issue_va", 32'(va), 32'h1FFFF);
    chk("blank_issue_vrd", 32'(vrd), 32'd1);
    tick(2);
    chk("blank_cmd_ack", 32'(cmd_ack), 32'd1);
    chk("blank_cmd_rdata", 32'(cmd_rdata), 32'h3E);
    chk("blank_disp_vld", 32'(disp_vld), 32'd0);
    chk("blank_disp_data", 32'(disp_data), 32'h5C);
    cmd_req = 1'b0;
    tick(2);

    // Contention over four free slots; priority must alternate CPU, CMD, CPU, CMD.
    disp_en = 1'b1; slot_disp = 1'b0;
    cpu_req = 1'b1; cpu_addr = 17'h00011;
    cmd_req = 1'b1; cmd_addr = 17'h00022;
    for (int s = 0; s < 4; s++) begin
      vd_in = 8'h11 * 8'(s + 1);
      slot_stb = 1'b1;
      tick(1);
      slot_stb = 1'b0;
      chk("cont_issue_va", 32'(va), (s % 2 == 0) ? 32'h00011 : 32'h00022);
      tick(2);
      chk("cont_cpu_ack", 32'(cpu_ack), (s % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_cmd_ack", 32'(cmd_ack), (s % 2 == 0) ? 32'd0 : 32'd1);
      if (s % 2 == 0) chk("cont_cpu_rdata", 32'(cpu_rdata), 32'(8'h11 * 8'(s + 1)));
      else            chk("cont_cmd_rdata", 32'(cmd_rdata), 32'(8'h11 * 8'(s + 1)));
      tick(2);
    end
    cpu_req = 1'b0; cmd_req = 1'b0;
    chk("cont_cpu_hold", 32'(cpu_rdata), 32'h33);
    tick(1);

    // Overrun: second strobe two clocks after the first is ignored.
    cpu_req = 1'b1; cpu_addr = 17'h00333; vd_in = 8'h77;
    slot_stb = 1'b1;
    tick(1);
    slot_stb = 1'b0;
    tick(1);
    cmd_req = 1'b1; cmd_addr = 17'h00055;
    slot_stb = 1'b1;
    tick(1);
    slot_stb = 1'b0; cpu_req = 1'b0;
    chk("ovr_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("ovr_cpu_rdata", 32'(cpu_rdata), 32'h77);
    chk("ovr_flag", 32'(overrun), 32'd1);
    tick(1);
    chk("ovr_cmd_noack", 32'(cmd_ack), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    tick(1);
    chk("ovr_no_access", 32'(vrd), 32'd0);
    chk("ovr_sticky2", 32'(overrun), 32'd1);
    cmd_req = 1'b0;
    tick(2);

    // Reset during WAIT aborts the access.
    cpu_req = 1'b1; cpu_addr = 17'h00444; vd_in = 8'h99;
    slot_stb = 1'b1;
    tick(1);
    slot_stb = 1'b0;
    tick(1);
    chk("rstm_wait_vrd", 32'(vrd), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstm_vrd", 32'(vrd), 32'd0);
    chk("rstm_ack", 32'(cpu_ack), 32'd0);
    chk("rstm_overrun", 32'(overrun), 32'd0);
    chk("rstm_va", 32'(va), 32'd0);
    tick(1);
    chk("rstm_ack2", 32'(cpu_ack), 32'd0);
    tick(1);
    slot_stb = 1'b1;
    tick(1);
    slot_stb = 1'b0;
    chk("rstm_next_va", 32'(va), 32'h00444);
    chk("rstm_next_vrd", 32'(vrd), 32'd1);
    tick(2);
    chk("rstm_next_ack", 32'(cpu_ack), 32'd1);
    chk("rstm_next_rdata", 32'(cpu_rdata), 32'h99);
    cpu_req = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
